// File: rtl/mult_accumulator.sv
// Accumulates a programmed number of 8-bit products into a saturating ACC_W-bit sum.
// The final result is held until the consumer accepts it.
module mult_accumulator #(
  parameter int unsigned ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       len,
  input  logic             p_valid,
  input  logic [7:0]       p_in,
  output logic             p_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             ovf
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic               p_ready_q, busy_q, out_valid_q;
  logic [SUM_W-1:0]   sum;
  logic               accept;

  // Status flags are registered from the next state so they always track state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      p_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      p_ready_q   <= (state_d == ACCUM);
      busy_q      <= (state_d != IDLE);
      out_valid_q <= (state_d == DONE);
    end
  end

  assign sum    = {1'b0, acc_q} + SUM_W'(p_in);
  assign accept = p_valid && (state_q == ACCUM);

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = len;
          state_d = (len != 4'd0) ? ACCUM : DONE;
        end
      end

      ACCUM: begin
        if (accept) begin
          if (sum[ACC_W]) begin
            acc_d = '1;
            ovf_d = 1'b1;
          end else begin
            acc_d = sum[ACC_W-1:0];
          end
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign p_ready   = p_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign acc_out   = acc_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mult_accumulator.sv
// Scoreboard bench for mult_accumulator: a default-width and an 8-bit instance.
module tb_mult_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-width instance (ACC_W = 12)
  logic        rst, start, p_valid, out_ready;
  logic [3:0]  len;
  logic [7:0]  p_in;
  logic        p_ready, out_valid, busy, ovf;
  logic [11:0] acc_out;

  // Narrow instance (ACC_W = 8)
  logic        rst8, start8, p_valid8, out_ready8;
  logic [3:0]  len8;
  logic [7:0]  p_in8;
  logic        p_ready8, out_valid8, busy8, ovf8;
  logic [7:0]  acc_out8;

  mult_accumulator dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .p_valid(p_valid),
    .p_in(p_in), .p_ready(p_ready), .acc_out(acc_out), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .ovf(ovf)
  );

  mult_accumulator #(.ACC_W(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .len(len8), .p_valid(p_valid8),
    .p_in(p_in8), .p_ready(p_ready8), .acc_out(acc_out8), .out_valid(out_valid8),
    .out_ready(out_ready8), .busy(busy8), .ovf(ovf8)
  );

  int checks = 0;
  int errors = 0;

  // Expected results: {ovf, acc}
  logic [16:0] q12[$];
  logic [16:0] q8[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: compare each new result against the scoreboard head.
  logic ov_prev = 1'b0;
  logic ov8_prev = 1'b0;
  always @(negedge clk) begin
    logic [16:0] e;
    if (out_valid === 1'b1 && !ov_prev) begin
      if (q12.size() == 0) begin
        chk("w12 unexpected out_valid", 32'(out_valid), 32'd0);
      end else begin
        e = q12.pop_front();
        chk("w12 result acc", 32'(acc_out), 32'(e[15:0]));
        chk("w12 result ovf", 32'(ovf), 32'(e[16]));
      end
    end
    ov_prev = (out_valid === 1'b1);
  end

  always @(negedge clk) begin
    logic [16:0] e;
    if (out_valid8 === 1'b1 && !ov8_prev) begin
      if (q8.size() == 0) begin
        chk("w8 unexpected out_valid", 32'(out_valid8), 32'd0);
      end else begin
        e = q8.pop_front();
        chk("w8 result acc", 32'(acc_out8), 32'(e[15:0]));
        chk("w8 result ovf", 32'(ovf8), 32'(e[16]));
      end
    end
    ov8_prev = (out_valid8 === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; p_valid = 1'b0; p_in = '0; out_ready = 1'b0;
    rst8 = 1'b1; start8 = 1'b0; len8 = '0; p_valid8 = 1'b0; p_in8 = '0; out_ready8 = 1'b0;
    tick(); tick();
    rst = 1'b0; rst8 = 1'b0;
    chk("reset acc", 32'(acc_out), 0);
    chk("reset ovf", 32'(ovf), 0);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset p_ready", 32'(p_ready), 0);
    chk("reset busy", 32'(busy), 0);

    // len=3: 225, 10, 0 back-to-back
    start = 1'b1; len = 4'd3; q12.push_back({1'b0, 16'd235});
    tick(); start = 1'b0;
    chk("s1 p_ready", 32'(p_ready), 1);
    chk("s1 busy", 32'(busy), 1);
    p_valid = 1'b1; p_in = 8'd225; tick();
    chk("s1 acc after 1", 32'(acc_out), 225);
    chk("s1 p_ready 2", 32'(p_ready), 1);
    p_in = 8'd10; tick();
    chk("s1 acc after 2", 32'(acc_out), 235);
    chk("s1 out_valid early", 32'(out_valid), 0);
    p_in = 8'd0; tick();
    p_valid = 1'b0;
    chk("s1 out_valid", 32'(out_valid), 1);
    chk("s1 p_ready in done", 32'(p_ready), 0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("s1 out_valid drop", 32'(out_valid), 0);
    chk("s1 busy idle", 32'(busy), 0);
    tick();
    chk("s1 acc held idle", 32'(acc_out), 235);

    // len=2: 7, gap of 3, 8
    start = 1'b1; len = 4'd2; q12.push_back({1'b0, 16'd15});
    tick(); start = 1'b0;
    p_valid = 1'b1; p_in = 8'd7; tick();
    p_valid = 1'b0; p_in = 8'd99;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s2 acc during gap", 32'(acc_out), 7);
      chk("s2 p_ready during gap", 32'(p_ready), 1);
    end
    p_valid = 1'b1; p_in = 8'd8; tick();
    p_valid = 1'b0;
    chk("s2 acc final", 32'(acc_out), 15);

    // DONE held with out_ready=0; start ignored
    for (int i = 0; i < 5; i++) begin
      start = (i == 2); len = 4'd5;
      tick();
      chk("s3 out_valid held", 32'(out_valid), 1);
      chk("s3 acc held", 32'(acc_out), 15);
    end
    start = 1'b0;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("s3 out_valid low", 32'(out_valid), 0);
    chk("s3 busy low", 32'(busy), 0);
    tick();
    chk("s3 still idle", 32'(busy), 0);

    // Reset mid-ACCUM after one accept
    start = 1'b1; len = 4'd3; tick(); start = 1'b0;
    p_valid = 1'b1; p_in = 8'd50; tick();
    chk("s5 acc before rst", 32'(acc_out), 50);
    p_valid = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
    chk("s5 acc after rst", 32'(acc_out), 0);
    chk("s5 busy after rst", 32'(busy), 0);
    chk("s5 p_ready after rst", 32'(p_ready), 0);
    chk("s5 ovf after rst", 32'(ovf), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s5 no out_valid", 32'(out_valid), 0);
    end
    // rst wins over start on the same edge
    rst = 1'b1; start = 1'b1; len = 4'd1; tick(); rst = 1'b0; start = 1'b0;
    chk("s5 rst over start", 32'(busy), 0);
    start = 1'b1; len = 4'd1; q12.push_back({1'b0, 16'd9});
    tick(); start = 1'b0;
    p_valid = 1'b1; p_in = 8'd9; tick(); p_valid = 1'b0;
    chk("s5 acc 9", 32'(acc_out), 9);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // len=0: straight to DONE
    start = 1'b1; len = 4'd0; q12.push_back({1'b0, 16'd0});
    tick(); start = 1'b0;
    chk("s6 out_valid", 32'(out_valid), 1);
    chk("s6 p_ready", 32'(p_ready), 0);
    chk("s6 acc", 32'(acc_out), 0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Maximum total at width 12 does not saturate
    start = 1'b1; len = 4'd15; q12.push_back({1'b0, 16'd3375});
    tick(); start = 1'b0;
    p_valid = 1'b1; p_in = 8'd225;
    for (int i = 0; i < 15; i++) tick();
    p_valid = 1'b0;
    chk("max acc", 32'(acc_out), 3375);
    chk("max ovf", 32'(ovf), 0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // ACC_W=8: 200 + 100 saturates
    start8 = 1'b1; len8 = 4'd2; q8.push_back({1'b1, 16'd255});
    tick(); start8 = 1'b0;
    p_valid8 = 1'b1; p_in8 = 8'd200; tick();
    chk("w8 acc 200", 32'(acc_out8), 200);
    chk("w8 ovf clear", 32'(ovf8), 0);
    p_in8 = 8'd100; tick(); p_valid8 = 1'b0;
    chk("w8 sat acc", 32'(acc_out8), 255);
    chk("w8 sat ovf", 32'(ovf8), 1);
    out_ready8 = 1'b1; tick(); out_ready8 = 1'b0;
    chk("w8 ovf sticky idle", 32'(ovf8), 1);

    // ACC_W=8: stays at all-ones after saturation
    start8 = 1'b1; len8 = 4'd3; q8.push_back({1'b1, 16'd255});
    tick(); start8 = 1'b0;
    chk("w8 start clears ovf", 32'(ovf8), 0);
    p_valid8 = 1'b1; p_in8 = 8'd250; tick();
    p_in8 = 8'd10; tick();
    p_in8 = 8'd0; tick(); p_valid8 = 1'b0;
    chk("w8 sat held", 32'(acc_out8), 255);
    out_ready8 = 1'b1; tick(); out_ready8 = 1'b0;

    // ACC_W=8: len=0 after overflow clears everything
    start8 = 1'b1; len8 = 4'd0; q8.push_back({1'b0, 16'd0});
    tick(); start8 = 1'b0;
    out_ready8 = 1'b1; tick(); out_ready8 = 1'b0;

    tick(); tick();
    chk("w12 scoreboard drained", 32'(q12.size()), 0);
    chk("w8 scoreboard drained", 32'(q8.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_accumulator.md
MULT_ACCUMULATOR -- requirements
Module: mult_accumulator

Interface
REQ-001: The block SHALL have one parameter, ACC_W, default 12, giving the accumulator and result width in bits; legal range is 8 to 16.
REQ-002: The block SHALL have the following ports, listed as name, direction, width, meaning:
- clk, input, 1, the single clock; all state changes on its rising edge.
- rst, input, 1, reset; synchronous and active-high.
- start, input, 1, begins a new accumulation when sampled in IDLE.
- len, input, 4, number of products to accumulate (0-15); sampled with start.
- p_valid, input, 1, product valid from the upstream 4x4 multiplier stage.
- p_in, input, 8, unsigned 8-bit product (the multiplier output p[7:0]).
- p_ready, output, 1, the block will accept p_in this cycle.
- acc_out, output, ACC_W, running or final accumulated sum.
- out_valid, output, 1, acc_out holds the final result.
- out_ready, input, 1, the consumer accepts the result.
- busy, output, 1, high whenever state is not IDLE.
- ovf, output, 1, sticky saturation flag for the current accumulation.

Function
REQ-003: The block SHALL implement a three-state FSM with states IDLE, ACCUM and DONE.
REQ-004: In IDLE, start=1 SHALL clear acc_out and ovf and load the counter with len; the next state SHALL be ACCUM if len!=0, else DONE.
REQ-005: start SHALL be ignored in ACCUM and DONE.
REQ-006: p_ready SHALL equal (state==ACCUM), decoded from the state register only with no combinational path from p_valid.
REQ-007: A product SHALL be accepted only on a cycle where p_valid and p_ready are both high; p_in on all other cycles SHALL be ignored.
REQ-008: On accept, acc_out SHALL be updated to acc_out + zero-extended p_in, computed at ACC_W+1 bits.
REQ-009: If that sum exceeds 2^ACC_W-1, acc_out SHALL saturate to all-ones and ovf SHALL set; ovf stays set until the next start or rst.
REQ-010: After saturation, further accepts SHALL leave acc_out at all-ones.
REQ-011: Each accept SHALL decrement the counter; the accept made while the counter equals 1 SHALL move the FSM to DONE.
REQ-012: Latency: out_valid SHALL rise on the cycle after the last accept (or the cycle after start when len=0).
REQ-013: In DONE, out_valid SHALL be 1, and acc_out and ovf SHALL be held stable until out_ready=1 is sampled.
REQ-014: In DONE, out_ready=1 SHALL return the FSM to IDLE, with out_valid low on the next cycle.
REQ-015: acc_out and ovf SHALL remain unchanged in IDLE after a completed transfer, until the next start.
REQ-016: busy SHALL be 1 in ACCUM and DONE, and 0 in IDLE.
REQ-017: Gaps in p_valid SHALL stall ACCUM indefinitely without any change to acc_out or the counter.
REQ-018: At the default ACC_W=12 the maximum total (15 x 225 = 3375) SHALL never saturate.

Reset
REQ-019: On rst=1 at a clock edge, the block SHALL force state=IDLE, acc_out=0, counter=0, ovf=0, out_valid=0, p_ready=0 and busy=0.
REQ-020: rst SHALL take priority over start, accepts and out_ready on the same edge.
REQ-021: rst asserted mid-ACCUM or mid-DONE SHALL abandon the operation with no out_valid pulse.

Verification
REQ-022: Directed scenarios:
- len=3; products 225, 10, 0 with p_valid held high -> p_ready high 3 cycles; out_valid the following cycle; acc_out=235; ovf=0.
- len=2; products 7 and 8 separated by 3 cycles of p_valid=0 -> acc_out unchanged during the gap; final acc_out=15.
- DONE with out_ready=0 for 5 cycles, start=1 pulsed meanwhile -> out_valid and acc_out held; start ignored; IDLE one cycle after out_ready=1.
- ACC_W=8; len=2; products 200 then 100 -> acc_out=255; ovf=1 at out_valid.
- rst after 1 of 3 products accepted -> all outputs 0 on the next cycle; no out_valid; then len=1, product 9 -> acc_out=9.
- len=0 with start -> out_valid on the next cycle; acc_out=0; p_ready never asserted.
